// File: rtl/cal_date_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cal_date_sched_pkg
// Brief    : Shared types, codes and calendar helpers for the date scheduler
// Revision : 1.0 - initial release
// ============================================================================
package cal_date_sched_pkg;

  // Scheduler states: one conversion slot per date field
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_Y = 2'd1,
    ST_CONV_M = 2'd2,
    ST_CONV_D = 2'd3
  } state_t;

  // Field select codes for the set interface; code 3 is reserved
  localparam logic [1:0] c_sel_year  = 2'd0;
  localparam logic [1:0] c_sel_month = 2'd1;
  localparam logic [1:0] c_sel_day   = 2'd2;

  // Month lengths
  localparam logic [4:0] c_dim_long  = 5'd31;
  localparam logic [4:0] c_dim_short = 5'd30;
  localparam logic [4:0] c_dim_feb   = 5'd28;
  localparam logic [4:0] c_dim_leap  = 5'd29;

  // Years 2000-2099: every year divisible by 4 is leap, only low bits matter
  function automatic logic is_leap(input logic [1:0] y_lo, input logic leap_en);
    return leap_en && (y_lo == 2'd0);
  endfunction

  // Days in month m for a year whose two low bits are y_lo
  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic [1:0] y_lo,
                                        input logic leap_en);
    case (m)
      4'd2:                      return is_leap(y_lo, leap_en) ? c_dim_leap : c_dim_feb;
      4'd4, 4'd6, 4'd9, 4'd11:   return c_dim_short;
      default:                   return c_dim_long;
    endcase
  endfunction

  // Elaboration-time BCD split, used only for reset digit values
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cal_date_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : cal_date_sched_if
// Brief    : Day-tick / set-control inputs and BCD date outputs
// Revision : 1.0 - initial release
// ============================================================================
interface cal_date_sched_if;
  logic       day_tick;
  logic       set_en;
  logic [1:0] set_sel;
  logic [6:0] set_val;
  logic       set_stb;
  logic       set_err;
  logic       year_wrap;
  logic [3:0] y_t, y_o;
  logic [3:0] m_t, m_o;
  logic [3:0] d_t, d_o;
  logic       bcd_valid;

  modport master (
    output day_tick, set_en, set_sel, set_val, set_stb,
    input  set_err, year_wrap, y_t, y_o, m_t, m_o, d_t, d_o, bcd_valid
  );

  modport slave (
    input  day_tick, set_en, set_sel, set_val, set_stb,
    output set_err, year_wrap, y_t, y_o, m_t, m_o, d_t, d_o, bcd_valid
  );
endinterface
`default_nettype wire

// File: rtl/cal_date_sched_sep.sv
`default_nettype none
// ============================================================================
// Module   : cal_date_sched_sep
// Brief    : WT_SEP_Y binary (0..99) to tens/ones BCD splitter, combinational
// Revision : 1.0 - initial release
// ============================================================================
module cal_date_sched_sep (
  input  wire logic [6:0] i_bin,
  output logic      [3:0] o_tens,
  output logic      [3:0] o_ones
);

  // Constant divisors reduce to small comparator/subtract logic
  always_comb begin
    o_tens = 4'(i_bin / 7'd10);
    o_ones = 4'(i_bin % 7'd10);
  end

endmodule
`default_nettype wire

// File: rtl/cal_date_sched.sv
`default_nettype none
// ============================================================================
// Module   : cal_date_sched
// Brief    : Day/month/year counter (2000-2099) with set control and a
//            scheduler sharing one BCD splitter across the three fields
// Revision : 1.0 - initial release
// ============================================================================
module cal_date_sched
  import cal_date_sched_pkg::*;
#(
  parameter int unsigned YEAR_MAX    = 99,
  parameter int unsigned RESET_YEAR  = 0,
  parameter int unsigned RESET_MONTH = 1,
  parameter int unsigned RESET_DAY   = 1,
  parameter bit          LEAP_EN     = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  cal_date_sched_if.slave  bus
);

  localparam logic [6:0] c_year_max  = 7'(YEAR_MAX);
  localparam logic [6:0] c_rst_year  = 7'(RESET_YEAR);
  localparam logic [3:0] c_rst_month = 4'(RESET_MONTH);
  localparam logic [4:0] c_rst_day   = 5'(RESET_DAY);
  localparam logic [7:0] c_rst_y_bcd = to_bcd(RESET_YEAR);
  localparam logic [7:0] c_rst_m_bcd = to_bcd(RESET_MONTH);
  localparam logic [7:0] c_rst_d_bcd = to_bcd(RESET_DAY);

  logic [6:0] r_year,  w_year_nxt;
  logic [3:0] r_month, w_month_nxt;
  logic [4:0] r_day,   w_day_nxt;
  logic [4:0] w_dim_cur, w_dim_set;
  logic       w_err, w_wrap, w_change;
  logic       r_set_err, r_year_wrap, r_dirty, r_valid;
  state_t     r_state, w_state_nxt;
  logic [6:0] w_sep_in;
  logic [3:0] w_sep_t, w_sep_o;
  logic [3:0] r_y_t, r_y_o, r_m_t, r_m_o, r_d_t, r_d_o;

  assign w_dim_cur = dim_of(r_month, r_year[1:0], LEAP_EN);

  // Next counter values from either a set strobe or a day tick (set mode drops ticks)
  always_comb begin
    w_year_nxt  = r_year;
    w_month_nxt = r_month;
    w_day_nxt   = r_day;
    w_dim_set   = w_dim_cur;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    if (bus.set_en) begin
      if (bus.set_stb) begin
        case (bus.set_sel)
          c_sel_year: begin
            if (bus.set_val <= c_year_max) begin
              w_year_nxt = bus.set_val;
              w_dim_set  = dim_of(r_month, bus.set_val[1:0], LEAP_EN);
              if (r_day > w_dim_set) w_day_nxt = w_dim_set;
            end else begin
              w_err = 1'b1;
            end
          end
          c_sel_month: begin
            if (bus.set_val != 7'd0 && bus.set_val <= 7'd12) begin
              w_month_nxt = bus.set_val[3:0];
              w_dim_set   = dim_of(bus.set_val[3:0], r_year[1:0], LEAP_EN);
              if (r_day > w_dim_set) w_day_nxt = w_dim_set;
            end else begin
              w_err = 1'b1;
            end
          end
          c_sel_day: begin
            if (bus.set_val != 7'd0 && bus.set_val <= {2'b00, w_dim_cur}) begin
              w_day_nxt = bus.set_val[4:0];
            end else begin
              w_err = 1'b1;
            end
          end
          default: w_err = 1'b1;
        endcase
      end
    end else if (bus.day_tick) begin
      if (r_day < w_dim_cur) begin
        w_day_nxt = r_day + 5'd1;
      end else begin
        w_day_nxt = 5'd1;
        if (r_month == 4'd12) begin
          w_month_nxt = 4'd1;
          if (r_year == c_year_max) begin
            w_year_nxt = 7'd0;
            w_wrap     = 1'b1;
          end else begin
            w_year_nxt = r_year + 7'd1;
          end
        end else begin
          w_month_nxt = r_month + 4'd1;
        end
      end
    end
  end

  assign w_change = (w_year_nxt != r_year) || (w_month_nxt != r_month) || (w_day_nxt != r_day);

  // Counters and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_year      <= c_rst_year;
      r_month     <= c_rst_month;
      r_day       <= c_rst_day;
      r_set_err   <= 1'b0;
      r_year_wrap <= 1'b0;
    end else begin
      r_year      <= w_year_nxt;
      r_month     <= w_month_nxt;
      r_day       <= w_day_nxt;
      r_set_err   <= w_err;
      r_year_wrap <= w_wrap;
    end
  end

  // Scheduler next state: a pending change always restarts from the year slot
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_dirty) w_state_nxt = ST_CONV_Y;
      ST_CONV_Y: w_state_nxt = ST_CONV_M;
      ST_CONV_M: w_state_nxt = ST_CONV_D;
      ST_CONV_D: w_state_nxt = r_dirty ? ST_CONV_Y : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, dirty flag and valid flag; a new change beats any clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dirty <= 1'b0;
      r_valid <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_change)
        r_dirty <= 1'b1;
      else if ((r_state == ST_IDLE && r_dirty) || r_state == ST_CONV_D)
        r_dirty <= 1'b0;
      if (w_change)
        r_valid <= 1'b0;
      else if (r_state == ST_CONV_D && !r_dirty)
        r_valid <= 1'b1;
    end
  end

  // Route the field owned by the current slot into the shared splitter
  always_comb begin
    case (r_state)
      ST_CONV_M: w_sep_in = {3'b000, r_month};
      ST_CONV_D: w_sep_in = {2'b00, r_day};
      default:   w_sep_in = r_year;
    endcase
  end

  cal_date_sched_sep u_wt_sep_y (
    .i_bin  (w_sep_in),
    .o_tens (w_sep_t),
    .o_ones (w_sep_o)
  );

  // Each digit pair latches on the edge that leaves its own conversion slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_y_t, r_y_o} <= c_rst_y_bcd;
      {r_m_t, r_m_o} <= c_rst_m_bcd;
      {r_d_t, r_d_o} <= c_rst_d_bcd;
    end else begin
      case (r_state)
        ST_CONV_Y: {r_y_t, r_y_o} <= {w_sep_t, w_sep_o};
        ST_CONV_M: {r_m_t, r_m_o} <= {w_sep_t, w_sep_o};
        ST_CONV_D: {r_d_t, r_d_o} <= {w_sep_t, w_sep_o};
        default: ;
      endcase
    end
  end

  assign bus.set_err   = r_set_err;
  assign bus.year_wrap = r_year_wrap;
  assign bus.bcd_valid = r_valid;
  assign bus.y_t       = r_y_t;
  assign bus.y_o       = r_y_o;
  assign bus.m_t       = r_m_t;
  assign bus.m_o       = r_m_o;
  assign bus.d_t       = r_d_t;
  assign bus.d_o       = r_d_o;

endmodule
`default_nettype wire

// File: tb/tb_cal_date_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cal_date_sched
// Brief    : Directed self-checking bench for cal_date_sched
// Revision : 1.0 - initial release
// ============================================================================
module tb_cal_date_sched;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cal_date_sched_if bus();

  cal_date_sched #(
    .YEAR_MAX    (99),
    .RESET_YEAR  (0),
    .RESET_MONTH (1),
    .RESET_DAY   (1),
    .LEAP_EN     (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] digits();
    return {8'h00, bus.y_t, bus.y_o, bus.m_t, bus.m_o, bus.d_t, bus.d_o};
  endfunction

  task automatic do_set(input logic [1:0] sel, input logic [6:0] val);
    bus.set_sel = sel;
    bus.set_val = val;
    bus.set_stb = 1'b1;
    @(negedge clk);
    bus.set_stb = 1'b0;
  endtask

  task automatic tick();
    bus.day_tick = 1'b1;
    @(negedge clk);
    bus.day_tick = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.bcd_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus.bcd_valid}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.day_tick = 1'b0;
    bus.set_en   = 1'b0;
    bus.set_sel  = 2'd0;
    bus.set_val  = 7'd0;
    bus.set_stb  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset state
    chk("rst_digits", digits(), 32'h000101);
    chk("rst_valid", {31'd0, bus.bcd_valid}, 32'd1);
    chk("rst_err", {31'd0, bus.set_err}, 32'd0);
    chk("rst_wrap", {31'd0, bus.year_wrap}, 32'd0);

    // 2: 2023-02-28 then one tick, with exact latency
    bus.set_en = 1'b1;
    do_set(2'd0, 7'd23);
    chk("set_y23_err", {31'd0, bus.set_err}, 32'd0);
    do_set(2'd1, 7'd2);
    do_set(2'd2, 7'd28);
    bus.set_en = 1'b0;
    wait_valid("t2_settle");
    chk("t2_digits_set", digits(), 32'h230228);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid_low", {31'd0, bus.bcd_valid}, 32'd0);
      @(negedge clk);
    end
    chk("t2_valid_k4", {31'd0, bus.bcd_valid}, 32'd1);
    chk("t2_digits_tick", digits(), 32'h230301);

    // 3: leap February 2024
    bus.set_en = 1'b1;
    do_set(2'd0, 7'd24);
    do_set(2'd1, 7'd2);
    do_set(2'd2, 7'd28);
    bus.set_en = 1'b0;
    wait_valid("t3_settle");
    chk("t3_digits_set", digits(), 32'h240228);
    tick();
    wait_valid("t3_tick1");
    chk("t3_feb29", digits(), 32'h240229);
    tick();
    wait_valid("t3_tick2");
    chk("t3_mar01", digits(), 32'h240301);

    // 4: year change off a leap year clamps Feb 29 to 28
    bus.set_en = 1'b1;
    do_set(2'd1, 7'd2);
    do_set(2'd2, 7'd29);
    wait_valid("t4_settle");
    chk("t4_digits_set", digits(), 32'h240229);
    do_set(2'd0, 7'd25);
    chk("t4_err", {31'd0, bus.set_err}, 32'd0);
    wait_valid("t4_clamp_settle");
    chk("t4_clamp", digits(), 32'h250228);

    // 5: end of century wraps to 2000-01-01
    do_set(2'd0, 7'd99);
    do_set(2'd1, 7'd12);
    do_set(2'd2, 7'd31);
    bus.set_en = 1'b0;
    wait_valid("t5_settle");
    chk("t5_digits_set", digits(), 32'h991231);
    chk("t5_wrap_idle", {31'd0, bus.year_wrap}, 32'd0);
    tick();
    chk("t5_wrap_pulse", {31'd0, bus.year_wrap}, 32'd1);
    @(negedge clk);
    chk("t5_wrap_end", {31'd0, bus.year_wrap}, 32'd0);
    wait_valid("t5_wrap_settle");
    chk("t5_digits_wrap", digits(), 32'h000101);

    // 6: rejections and ignored inputs
    bus.set_en = 1'b1;
    do_set(2'd1, 7'd13);
    chk("t6_m13_err", {31'd0, bus.set_err}, 32'd1);
    chk("t6_m13_valid", {31'd0, bus.bcd_valid}, 32'd1);
    @(negedge clk);
    chk("t6_err_end", {31'd0, bus.set_err}, 32'd0);
    do_set(2'd3, 7'd5);
    chk("t6_sel3_err", {31'd0, bus.set_err}, 32'd1);
    do_set(2'd2, 7'd0);
    chk("t6_day0_err", {31'd0, bus.set_err}, 32'd1);
    tick();
    chk("t6_tick_set_valid", {31'd0, bus.bcd_valid}, 32'd1);
    bus.set_en = 1'b0;
    do_set(2'd1, 7'd13);
    chk("t6_stb_noen_err", {31'd0, bus.set_err}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_valid", {31'd0, bus.bcd_valid}, 32'd1);
    chk("t6_digits", digits(), 32'h000101);

    // 7: tick during CONV_M forces a second full pass
    tick();
    @(negedge clk);
    @(negedge clk);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t7_valid_low", {31'd0, bus.bcd_valid}, 32'd0);
      @(negedge clk);
    end
    chk("t7_valid_pass2", {31'd0, bus.bcd_valid}, 32'd1);
    chk("t7_digits", digits(), 32'h000103);

    // 8: asynchronous reset mid-conversion
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_valid", {31'd0, bus.bcd_valid}, 32'd1);
    chk("t8_rst_digits", digits(), 32'h000101);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t8_hold_valid", {31'd0, bus.bcd_valid}, 32'd1);
    tick();
    wait_valid("t8_tick_settle");
    chk("t8_tick_digits", digits(), 32'h000102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
